// File: rtl/sma_in_pkg.sv
// -----------------------------------------------------------------------------
// sma_in_pkg
// Shared definitions for the SMA input edge timer: Avalon register addresses,
// CTRL/STATUS bit positions, the polarity bit of a FIFO word and a helper that
// assembles the STATUS read word.
// -----------------------------------------------------------------------------
package sma_in_pkg;

  // Avalon word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_FIFO   = 2'd3;

  // CTRL register bit indices
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_RISE_EN_BIT = 1;
  localparam int CTRL_FALL_EN_BIT = 2;
  localparam int CTRL_IRQ_EN_BIT  = 3;
  localparam int CTRL_WIDTH       = 4;

  // STATUS register bit indices
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_W   = 8;

  // FIFO word layout: polarity in the MSB, timestamp below it
  localparam int POL_BIT = 31;

  // Field order mirrors the CTRL bit indices above (en is bit 0)
  typedef struct packed {
    logic irq_en;
    logic fall_en;
    logic rise_en;
    logic en;
  } ctrl_t;

  // Builds the 32-bit STATUS read word from the FIFO flags and fill count
  function automatic logic [31:0] pack_status(input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic [7:0] count);
    logic [31:0] w;
    w = 32'd0;
    w[STATUS_EMPTY_BIT] = empty;
    w[STATUS_FULL_BIT]  = full;
    w[STATUS_OVF_BIT]   = ovf;
    w[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/sma_in_ts_fifo.sv
// -----------------------------------------------------------------------------
// sma_in_ts_fifo
// Synchronous timestamp FIFO with sticky overflow flag.
//   clk_i       system clock
//   reset_n_i   synchronous active-low reset (empties FIFO, clears overflow)
//   push_i      write push_data_i if there is room (or a pop frees a slot)
//   push_data_i word to enqueue
//   pop_i       drop the head word; ignored while empty
//   ovf_clr_i   clear the sticky overflow flag
//   head_o      current head word (valid while empty_o is 0)
//   empty_o     no entries stored
//   full_o      DEPTH entries stored
//   count_o     number of stored entries
//   overflow_o  sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module sma_in_ts_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         ovf_clr_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic empty_s;
  logic full_s;
  logic pop_ok_s;
  logic push_ok_s;
  logic ovf_evt_s;

  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign full_s  = (count_q == DEPTH_C);

  // Pointer, count and overflow next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // A pop on an empty FIFO is a no-op; a pop frees the slot a
    // same-cycle push into a full FIFO needs.
    pop_ok_s  = pop_i & ~empty_s;
    push_ok_s = push_i & (~full_s | pop_ok_s);
    ovf_evt_s = push_i & full_s & ~pop_ok_s;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new overflow event wins over a simultaneous clear
    overflow_d = (overflow_q & ~ovf_clr_i) | ovf_evt_s;
  end

  // Pointer, count and overflow registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    if (reset_n_i && push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o     = mem_q[rd_ptr_q];
  assign empty_o    = empty_s;
  assign full_o     = full_s;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sma_in_edge_timer.sv
// -----------------------------------------------------------------------------
// sma_in_edge_timer
// Avalon-MM slave that synchronises the SMA input pin, detects rising/falling
// edges, stamps each enabled edge with a free-running cycle counter and queues
// the stamps for the host. The interrupt is raised while stamps are pending or
// an overflow has occurred (when enabled).
//   clk        system clock
//   reset_n    synchronous active-low reset
//   address    Avalon word address (0 DATA, 1 CTRL, 2 STATUS, 3 FIFO)
//   read       Avalon read strobe; readdata is valid the following cycle
//   write      Avalon write strobe
//   writedata  Avalon write data
//   readdata   registered read data, holds between reads
//   irq        registered level interrupt
//   in_port    asynchronous SMA pin
// FIFO word: bit 31 = 1 for a rising edge, bits [30:0] = zero-extended stamp.
// -----------------------------------------------------------------------------
module sma_in_edge_timer
  import sma_in_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        in_port
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  ctrl_t                   ctrl_q, ctrl_d;
  logic [TS_WIDTH-1:0]     ts_cnt_q, ts_cnt_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    prev_q, prev_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [31:0]             readdata_q, readdata_d;
  logic                    irq_q, irq_d;

  logic                    s_s;
  logic [30:0]             ts_ext_s;
  logic                    push_s;
  logic [31:0]             push_word_s;
  logic                    pop_s;
  logic                    ovf_clr_s;
  logic [31:0]             rd_mux_s;
  logic [31:0]             fifo_head_s;
  logic                    fifo_empty_s;
  logic                    fifo_full_s;
  logic                    fifo_ovf_s;
  logic [CNT_W-1:0]        fifo_count_s;
  logic [27:0]             unused_wdata_s;

  assign unused_wdata_s = writedata[31:4];

  assign s_s = sync_q[SYNC_STAGES-1];

  // CTRL write decode and timestamp counter next state
  always_comb begin
    ctrl_d   = ctrl_q;
    ts_cnt_d = ts_cnt_q;
    if (write && (address == ADDR_CTRL)) begin
      ctrl_d = ctrl_t'(writedata[CTRL_WIDTH-1:0]);
    end else begin
      ctrl_d = ctrl_q;
    end
    // Wraps silently modulo 2^TS_WIDTH
    if (ctrl_q.en) begin
      ts_cnt_d = ts_cnt_q + TS_WIDTH'(1);
    end else begin
      ts_cnt_d = ts_cnt_q;
    end
  end

  // Synchroniser shift, edge detect and registered edge strobes
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
    prev_d = s_s;
    // Edges are registered once so the stamp is taken in the detect cycle
    // that follows the synchroniser, independent of enable state.
    rise_d = s_s & ~prev_q;
    fall_d = ~s_s & prev_q;
  end

  // Push qualification and FIFO word assembly
  always_comb begin
    ts_ext_s    = 31'(ts_cnt_q);
    push_s      = ctrl_q.en & ((rise_q & ctrl_q.rise_en) | (fall_q & ctrl_q.fall_en));
    push_word_s = {rise_q, ts_ext_s};
  end

  // Bus side effects: FIFO pop and overflow write-one-to-clear
  always_comb begin
    pop_s     = read & (address == ADDR_FIFO);
    ovf_clr_s = write & (address == ADDR_STATUS) & writedata[STATUS_OVF_BIT];
  end

  // Read multiplexer; uses register state before any same-cycle write
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      ADDR_DATA:   rd_mux_s[0] = s_s;
      ADDR_CTRL:   rd_mux_s[CTRL_WIDTH-1:0] = ctrl_q;
      ADDR_STATUS: rd_mux_s = pack_status(fifo_empty_s, fifo_full_s, fifo_ovf_s,
                                          8'(fifo_count_s));
      ADDR_FIFO: begin
        if (fifo_empty_s) begin
          rd_mux_s = 32'd0;
        end else begin
          rd_mux_s = fifo_head_s;
        end
      end
      default:     rd_mux_s = 32'd0;
    endcase
  end

  // readdata holds between reads; irq follows pending/overflow when enabled
  always_comb begin
    if (read) begin
      readdata_d = rd_mux_s;
    end else begin
      readdata_d = readdata_q;
    end
    irq_d = ctrl_q.irq_en & (~fifo_empty_s | fifo_ovf_s);
  end

  // Control, counter, synchroniser, edge and bus output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      ts_cnt_q   <= {TS_WIDTH{1'b0}};
      sync_q     <= {SYNC_STAGES{1'b0}};
      prev_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      ts_cnt_q   <= ts_cnt_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  sma_in_ts_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .push_i      (push_s),
    .push_data_i (push_word_s),
    .pop_i       (pop_s),
    .ovf_clr_i   (ovf_clr_s),
    .head_o      (fifo_head_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s),
    .count_o     (fifo_count_s),
    .overflow_o  (fifo_ovf_s)
  );

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/sma_in_edge_timer.md
Name: sma_in_edge_timer

Overview:
- Avalon-MM slave controller for the board's single-bit SMA input.
- Synchronizes the pin and detects rising and/or falling edges.
- Stamps each detected edge with a free-running cycle counter and queues the stamps in a small FIFO for the Nios host to drain.
- Raises an interrupt while stamps are pending or an overflow has occurred; replaces the bare level-read PIO when the software needs edge timing.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops (min 2).
- FIFO_DEPTH, 8, timestamp FIFO entries (power of two, 2..64).
- TS_WIDTH, 31, timestamp counter width; bit 31 of a FIFO word carries polarity.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- address  in  2  Avalon word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered read data, valid the cycle after read.
- irq  out  1  registered level interrupt.
- in_port  in  1  asynchronous SMA pin.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - readdata=0, irq=0, CTRL=0.
  - FIFO emptied, overflow cleared, timestamp counter=0, synchronizer flops=0.
- Timestamp counter:
  - Increments every clk while CTRL.en=1; holds while en=0.
  - Wraps modulo 2^TS_WIDTH with no flag.
- Synchronizer and edge detect:
  - in_port passes through SYNC_STAGES flops to s.
  - prev is s delayed one cycle; rise = s & ~prev, fall = ~s & prev.
  - Edge detection stays active while en=0, but nothing is pushed.
- Push:
  - Condition: en & ((rise & CTRL.rise_en) | (fall & CTRL.fall_en)).
  - Word = {rise ? 1'b1 : 1'b0, counter}, using the counter value in the detect cycle.
  - Latency: an in_port transition before clk edge N appears in the FIFO after edge N+SYNC_STAGES+1.
- Register map (addr: access, fields):
  - 0 DATA: RO; bit0 = s.
  - 1 CTRL: RW; bit0 en, bit1 rise_en, bit2 fall_en, bit3 irq_en; upper bits read 0.
  - 2 STATUS: bit0 empty (RO), bit1 full (RO), bit2 overflow (sticky, W1C), bits[15:8] fill count (RO).
  - 3 FIFO: RO; a read returns the head word and pops it. A read while empty returns 0 and does not pop.
- Bus rules:
  - readdata is updated only on read cycles and holds otherwise.
  - Writes to addresses 0 and 3 are ignored.
  - read and write asserted together: the write takes effect and the read returns the pre-write value.
- FIFO boundaries:
  - Push while full with no pop in the same cycle: word dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed; count unchanged; no overflow.
  - Push and pop in the same cycle while empty: the pop is a no-op (returns 0); the push succeeds; count becomes 1.
  - Overflow W1C and a new overflow event in the same cycle: overflow stays 1.
  - Pointers wrap modulo FIFO_DEPTH.
- irq:
  - Next-state value = irq_en & (~empty | overflow), registered, so irq lags its cause by 1 cycle.
- Reset mid-operation:
  - Any reset cycle discards FIFO contents and pending reads; readdata reads 0 on the following cycle.

Decomposition:
- Shared package sma_in_pkg holds:
  - Register address constants: ADDR_DATA=0, ADDR_CTRL=1, ADDR_STATUS=2, ADDR_FIFO=3.
  - CTRL bit indices and STATUS bit indices.
  - Polarity bit position 31.
- One sub-module, sma_in_ts_fifo: synchronous FIFO with push, pop, full, empty, count and overflow, parameterised on DEPTH and 32-bit width, same clk/reset_n.

Test Plan:
- Reset then read all addresses -> DATA=0, CTRL=0, STATUS=0x00000001, FIFO=0, irq=0.
- Write CTRL=0x3; hold in_port=0, raise it at counter value 100 -> FIFO read returns 0x80000000|(100+SYNC_STAGES+1); STATUS.empty returns to 1.
- CTRL=0xF; pulse in_port high for 5 cycles -> two entries: rise (bit31=1) then fall (bit31=0), timestamps differing by 5; irq=1 until the second pop, then 0 one cycle later.
- CTRL=0x3; 9 rising edges with no reads -> count=8, full=1, overflow=1; the 9th stamp is absent; writing STATUS=0x4 clears overflow only.
- FIFO full, then an edge arrives in the same cycle as a FIFO pop -> count stays 8, overflow stays 0, oldest word returned.
- Preload counter near 2^31-1 (force or long run), then take an edge after the wrap -> stamp is a small value and ordering in the FIFO is preserved.
